a0_seg7_display: RTL and testbench
==================================

Name: a0_seg7_display

Overview:
- Display-side consumer of the CPU's 32-bit `a0` result output.
- Latches `a0` once per refresh frame, so digits never tear mid-scan.
- Drives an 8-digit, time-multiplexed seven-segment display with the value in hexadecimal.
- Sits at board top level, between `pipeline_mips_cpu.a0` and the display pins.

Parameters:
- CLK_DIV, 100000, clk cycles each digit stays enabled (legal range ≥2).
- BLANK_LEADING, 1, when 1 leading zero digits are blanked; digit 0 is never blanked.
- ACTIVE_LOW, 1, when 1 the `an`, `seg` and `dp` outputs are inverted (common-anode board).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a0  input  32  value to display, driven by the CPU.
- freeze  input  1  when 1, the frame-boundary reload of the shadow value is suppressed.
- an  output  8  digit enables; bit i = digit i; digit 0 = least significant nibble.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, held at its inactive level.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Single clock domain; all state updates on rising clk.
- rst is synchronous and active-high; it overrides all other activity.
- Reset values:
  - div_cnt=0, dig=0, shadow=0, frame_done=0.
  - an, seg, dp all inactive: with ACTIVE_LOW=1 that is an=8'hFF, seg=7'h7F, dp=1; with ACTIVE_LOW=0 all zero.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (div_cnt==CLK_DIV-1).
- Digit index:
  - dig is 3 bits, advances on tick, wraps 7→0.
  - No other event alters it.
- Frame boundary:
  - Condition is tick && dig==7.
  - shadow <= a0 at the boundary, unless freeze==1, in which case shadow holds.
  - frame_done is registered and asserts for exactly one cycle: the cycle after the boundary edge, coincident with the new shadow value.
- Shadow and a0 timing:
  - a0 is sampled only at boundary edges.
  - a0 changes between boundaries are invisible until the next boundary.
  - Reset mid-frame discards the frame: shadow=0 and scanning restarts at digit 0.
- Nibble decode (active-high {g..a}):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Blanking:
  - With BLANK_LEADING=1, digit i (i≥1) is blank when shadow[31:4i]==0.
  - A blank digit has seg=all-off, but its `an` bit is still asserted so scan timing is unchanged.
  - The value 0 shows a single '0' on digit 0.
- Output pipeline:
  - an, seg and dp are registered from the current dig and shadow: one cycle of latency after dig or shadow changes.
  - Exactly one `an` bit is active at any time outside reset, namely bit (dig of previous cycle).
  - ACTIVE_LOW inversion is applied after the register logic; it does not add latency.
- Frame period: 8*CLK_DIV cycles. Digit dwell: CLK_DIV cycles.
- freeze asserted on the same edge as a boundary blocks that reload; frame_done still pulses.

Test Plan (CLK_DIV=4, ACTIVE_LOW=1, BLANK_LEADING=1 unless stated):
- Reset, a0=0:
  - During reset: an=FF, seg=7F, dp=1, frame_done=0.
  - Cycle 1 after release: an=FE, seg=~3F=40.
  - Digits 1..7 show seg=7F (blank).
- a0=32'h0000_00A5:
  - After the first frame_done pulse, digit 0 gives seg=~6D=12, digit 1 gives seg=~77=08, digits 2..7 are blank.
  - Each an bit is low for exactly 4 cycles; the frame repeats every 32 cycles.
- a0=32'h1234_5678 with BLANK_LEADING=0, changed to 32'hDEAD_BEEF mid-frame:
  - Remaining digits keep showing 1234_5678 until the boundary.
  - frame_done pulses, then the next scan shows DEADBEEF (digit 7 seg=~5E=21).
- freeze=1 across two boundaries while a0 toggles:
  - The displayed value is unchanged.
  - frame_done still pulses every 32 cycles.
  - After freeze=0, the new a0 is shown from the following frame.
- rst asserted at dig=5 mid-dwell:
  - Next cycle: an=FF, shadow=0.
  - After release: scan restarts at digit 0 and div_cnt starts from 0.
- ACTIVE_LOW=0, a0=8:
  - Digit 0 gives an=01, seg=7F, dp=0.
  - Blank digits give seg=00.

Source files
------------

// File: rtl/a0_seg7_display.sv
// Eight-digit multiplexed hex display of the CPU a0 result.
// a0 is captured once per scan frame so digits never tear mid-refresh.
module a0_seg7_display #(
  parameter int unsigned CLK_DIV       = 100000,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a0,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned DIG_W   = 3;
  localparam int unsigned VAL_W   = 32;
  localparam int unsigned AN_W    = 8;
  localparam int unsigned SEG_W   = 7;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(7);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [VAL_W-1:0] shadow_q, shadow_d;
  logic             frame_done_q, frame_done_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;

  logic             tick;
  logic             boundary;
  logic [4:0]       nib_base;
  logic [3:0]       nibble;
  logic [VAL_W-1:0] upper;
  logic             blank;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] n);
    logic [SEG_W-1:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (div_cnt_q == DIV_MAX);
    boundary = tick && (dig_q == DIG_MAX);
  end

  // Scan divider, digit index and once-per-frame shadow reload.
  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
    dig_d        = tick ? dig_q + DIG_W'(1) : dig_q;
    shadow_d     = (boundary && !freeze) ? a0 : shadow_q;
    frame_done_d = boundary;
  end

  // Digit decode; a digit is blank when it and everything above it is zero.
  always_comb begin
    nib_base = {dig_q, 2'b00};
    nibble   = shadow_q[nib_base +: 4];
    upper    = shadow_q >> nib_base;
    blank    = BLANK_LEADING && (dig_q != '0) && (upper == '0);
    an_d     = AN_W'(1) << dig_q;
    seg_d    = blank ? '0 : hex7(nibble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      dig_q        <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      an_q         <= '0;
      seg_q        <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_q        <= dig_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  // Pin polarity is a pure inversion of the registered active-high values.
  assign an         = ACTIVE_LOW ? ~an_q : an_q;
  assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp         = ACTIVE_LOW;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_a0_seg7_display.sv
// Bench for a0_seg7_display: three parameterisations share clk/rst/a0/freeze and
// are compared against a cycle-count reference model of the scan.
module tb_a0_seg7_display;

  localparam int CDIV  = 4;
  localparam int FRAME = 8 * CDIV;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a0 = '0;
  logic        freeze = 1'b0;

  logic [7:0] an1, an_n, an_h;
  logic [6:0] seg1, seg_n, seg_h;
  logic       dp1, dp_n, dp_h;
  logic       fd1, fd_n, fd_h;

  int total = 0;
  int bad   = 0;

  // Reference model state: released cycles since reset and the displayed value.
  int          t = 0;
  logic [31:0] m_shadow = '0;
  bit          e_rst;
  int          e_dig;
  bit          e_fd;
  logic [7:0]  e_an1, e_an0;
  logic [6:0]  e_seg1, e_segn, e_seg0;

  always #5 clk = ~clk;

  a0_seg7_display #(.CLK_DIV(CDIV), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .a0(a0), .freeze(freeze),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1));

  a0_seg7_display #(.CLK_DIV(CDIV), .BLANK_LEADING(1'b0), .ACTIVE_LOW(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .a0(a0), .freeze(freeze),
    .an(an_n), .seg(seg_n), .dp(dp_n), .frame_done(fd_n));

  a0_seg7_display #(.CLK_DIV(CDIV), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .a0(a0), .freeze(freeze),
    .an(an_h), .seg(seg_h), .dp(dp_h), .frame_done(fd_h));

  function automatic logic [6:0] ref_seg(input logic [31:0] v, input int d, input bit bl);
    longint unsigned q;
    q = 64'(v) / (64'd1 << (4 * d));
    if (bl && d > 0 && q == 0) return 7'h00;
    return SEG_TBL[int'(q % 16)];
  endfunction

  // One clock: advance the model using the inputs that the DUT samples on this edge.
  task automatic step();
    logic [31:0] a0_s;
    logic        fr_s;
    logic        rst_s;
    a0_s  = a0;
    fr_s  = freeze;
    rst_s = rst;
    @(posedge clk);
    #1;
    if (rst_s) begin
      t = 0; m_shadow = '0; e_rst = 1'b1; e_fd = 1'b0; e_dig = 0;
      e_an1 = 8'hFF; e_seg1 = 7'h7F; e_segn = 7'h7F; e_an0 = 8'h00; e_seg0 = 7'h00;
    end else begin
      e_rst  = 1'b0;
      e_dig  = (t / CDIV) % 8;
      e_fd   = (t % FRAME) == FRAME - 1;
      e_an0  = 8'(1 << e_dig);
      e_an1  = ~e_an0;
      e_seg0 = ref_seg(m_shadow, e_dig, 1'b1);
      e_seg1 = ~e_seg0;
      e_segn = ~ref_seg(m_shadow, e_dig, 1'b0);
      if (e_fd && !fr_s) m_shadow = a0_s;
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a0 = '0; freeze = 1'b0;
    step(); step(); step();
    total++;
    if (an1 !== 8'hFF || seg1 !== 7'h7F || dp1 !== 1'b1 || fd1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_al: an=%h seg=%h dp=%b fd=%b expected an=ff seg=7f dp=1 fd=0", an1, seg1, dp1, fd1);
    end
    total++;
    if (an_h !== 8'h00 || seg_h !== 7'h00 || dp_h !== 1'b0 || fd_h !== 1'b0) begin
      bad++;
      $display("FAIL reset_ah: an=%h seg=%h dp=%b fd=%b expected all zero", an_h, seg_h, dp_h, fd_h);
    end
    rst = 1'b0;
    step();
    total++;
    if (an1 !== 8'hFE || seg1 !== 7'h40) begin
      bad++;
      $display("FAIL first_after_reset: an=%h seg=%h expected an=fe seg=40", an1, seg1);
    end
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      total++;
      if (an1 !== e_an1 || seg1 !== e_seg1 || fd1 !== e_fd) begin
        bad++;
        $display("FAIL zero_scan t=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 t, an1, seg1, fd1, e_an1, e_seg1, e_fd);
      end
    end
  endtask

  task automatic test_a5();
    int n;
    int lowc [8];
    a0 = 32'h0000_00A5;
    n = 0;
    do begin
      step(); n++;
      total++;
      if (an1 !== e_an1 || seg1 !== e_seg1 || fd1 !== e_fd) begin
        bad++;
        $display("FAIL a5_wait t=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 t, an1, seg1, fd1, e_an1, e_seg1, e_fd);
      end
    end while (fd1 !== 1'b1 && n < 2 * FRAME);
    total++;
    if (fd1 !== 1'b1) begin
      bad++;
      $display("FAIL a5_timeout: frame_done=%b expected 1 within %0d cycles", fd1, 2 * FRAME);
    end
    for (int i = 0; i < 8; i++) lowc[i] = 0;
    for (int c = 1; c <= FRAME; c++) begin
      logic [6:0] want;
      step();
      for (int i = 0; i < 8; i++) if (an1[i] == 1'b0) lowc[i]++;
      want = (e_dig == 0) ? 7'h12 : (e_dig == 1) ? 7'h08 : 7'h7F;
      total++;
      if (an1 !== e_an1 || seg1 !== want || fd1 !== (c == FRAME)) begin
        bad++;
        $display("FAIL a5_scan c=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 c, an1, seg1, fd1, e_an1, want, (c == FRAME));
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (lowc[i] != CDIV) begin
        bad++;
        $display("FAIL a5_dwell digit %0d: low cycles=%0d expected %0d", i, lowc[i], CDIV);
      end
    end
  endtask

  task automatic test_midframe();
    int n;
    a0 = 32'h1234_5678;
    n = 0;
    do begin step(); n++; end while (fd_n !== 1'b1 && n < 2 * FRAME);
    total++;
    if (fd_n !== 1'b1 || e_fd !== 1'b1) begin
      bad++;
      $display("FAIL mid_timeout: frame_done=%b expected 1", fd_n);
    end
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == FRAME / 2) a0 = 32'hDEAD_BEEF;
      step();
      total++;
      if (an_n !== e_an1 || seg_n !== e_segn || fd_n !== e_fd || dp_n !== 1'b1) begin
        bad++;
        $display("FAIL mid_scan c=%0d: an=%h seg=%h fd=%b dp=%b expected an=%h seg=%h fd=%b dp=1",
                 c, an_n, seg_n, fd_n, dp_n, e_an1, e_segn, e_fd);
      end
      if (c > FRAME / 2 && c < FRAME && e_dig == 7) begin
        total++;
        if (seg_n !== 7'h79) begin
          bad++;
          $display("FAIL mid_old_digit7: seg=%h expected 79", seg_n);
        end
      end
      if (c > 2 * FRAME && e_dig == 7) begin
        total++;
        if (seg_n !== 7'h21) begin
          bad++;
          $display("FAIL mid_new_digit7: seg=%h expected 21", seg_n);
        end
      end
    end
  endtask

  task automatic test_freeze();
    int fd_cnt;
    logic [31:0] held;
    logic [31:0] v;
    held = m_shadow;
    freeze = 1'b1;
    fd_cnt = 0;
    for (int c = 0; c < 2 * FRAME + 8; c++) begin
      if (c % 5 == 0) a0 = $urandom;
      step();
      if (fd1 === 1'b1) fd_cnt++;
      total++;
      if (an1 !== e_an1 || seg1 !== ~ref_seg(held, e_dig, 1'b1) || fd1 !== e_fd) begin
        bad++;
        $display("FAIL freeze_hold c=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 c, an1, seg1, fd1, e_an1, 7'(~ref_seg(held, e_dig, 1'b1)), e_fd);
      end
    end
    total++;
    if (fd_cnt != 2) begin
      bad++;
      $display("FAIL freeze_pulses: frame_done pulses=%0d expected 2", fd_cnt);
    end
    freeze = 1'b0;
    v = $urandom;
    a0 = v;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      step();
      total++;
      if (an1 !== e_an1 || seg1 !== e_seg1 || fd1 !== e_fd) begin
        bad++;
        $display("FAIL unfreeze c=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 c, an1, seg1, fd1, e_an1, e_seg1, e_fd);
      end
    end
    total++;
    if (m_shadow !== v || seg_n !== ~ref_seg(v, e_dig, 1'b0)) begin
      bad++;
      $display("FAIL unfreeze_value: seg=%h expected %h", seg_n, 7'(~ref_seg(v, e_dig, 1'b0)));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    a0 = 32'hCAFE_0123;
    n = 0;
    while (t % FRAME != 5 * CDIV + 1 && n < 2 * FRAME) begin step(); n++; end
    rst = 1'b1;
    step();
    total++;
    if (an1 !== 8'hFF || seg1 !== 7'h7F || fd1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: an=%h seg=%h fd=%b expected an=ff seg=7f fd=0", an1, seg1, fd1);
    end
    rst = 1'b0;
    for (int c = 0; c < CDIV + 2; c++) begin
      logic [7:0] want_an;
      step();
      want_an = (c < CDIV) ? 8'hFE : 8'hFD;
      total++;
      if (an1 !== want_an || (c < CDIV && seg1 !== 7'h40) || an1 !== e_an1 || seg1 !== e_seg1) begin
        bad++;
        $display("FAIL rst_restart c=%0d: an=%h seg=%h expected an=%h seg=%h",
                 c, an1, seg1, want_an, e_seg1);
      end
    end
  endtask

  task automatic test_active_high();
    int n;
    a0 = 32'h0000_0008;
    n = 0;
    do begin step(); n++; end while (fd_h !== 1'b1 && n < 2 * FRAME);
    total++;
    if (fd_h !== 1'b1) begin
      bad++;
      $display("FAIL ah_timeout: frame_done=%b expected 1", fd_h);
    end
    for (int c = 0; c < FRAME; c++) begin
      logic [7:0] want_an;
      logic [6:0] want_seg;
      step();
      want_an  = 8'(1 << e_dig);
      want_seg = (e_dig == 0) ? 7'h7F : 7'h00;
      total++;
      if (an_h !== want_an || seg_h !== want_seg || dp_h !== 1'b0 || fd_h !== e_fd) begin
        bad++;
        $display("FAIL ah_scan c=%0d: an=%h seg=%h dp=%b fd=%b expected an=%h seg=%h dp=0 fd=%b",
                 c, an_h, seg_h, dp_h, fd_h, want_an, want_seg, e_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 6) == 0) a0 = $urandom >> $urandom_range(0, 31);
      freeze = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      step();
      total++;
      if (an1 !== e_an1 || seg1 !== e_seg1 || dp1 !== 1'b1 || fd1 !== e_fd) begin
        bad++;
        $display("FAIL rand_al c=%0d: an=%h seg=%h dp=%b fd=%b expected an=%h seg=%h dp=1 fd=%b",
                 c, an1, seg1, dp1, fd1, e_an1, e_seg1, e_fd);
      end
      total++;
      if (an_n !== e_an1 || seg_n !== e_segn || fd_n !== e_fd) begin
        bad++;
        $display("FAIL rand_nb c=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 c, an_n, seg_n, fd_n, e_an1, e_segn, e_fd);
      end
      total++;
      if (an_h !== e_an0 || seg_h !== e_seg0 || dp_h !== 1'b0 || fd_h !== e_fd) begin
        bad++;
        $display("FAIL rand_ah c=%0d: an=%h seg=%h dp=%b fd=%b expected an=%h seg=%h dp=0 fd=%b",
                 c, an_h, seg_h, dp_h, fd_h, e_an0, e_seg0, e_fd);
      end
    end
    rst = 1'b0;
    freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a5();
    test_midframe();
    test_freeze();
    test_reset_mid();
    test_active_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
